ifetch_unit: RTL
================

# ifetch_unit

Instruction fetch stage for the CPU, upstream of the IBus master. Owns the PC, issues word reads through the master's read-enable/address/zero-output controls, honours IBus wait requests, and buffers returned instructions in a 2-entry queue with a valid/ready handshake toward decode. Branch/jump redirects flush the queue and squash in-flight reads through the master's zero-output path.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; word aligned.
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- o_RdEn  out  1  read request to the IBus master.
- o_CpuAddr  out  32  fetch address; bits [1:0] always 0.
- o_OZero  out  1  forces the master's returned data to zero for a squashed response.
- i_CpuRd  in  32  instruction from the master, valid the cycle after an accepted request.
- i_IBus_WaitReq  in  1  bus stall; a request is accepted only in a cycle with o_RdEn=1 and i_IBus_WaitReq=0.
- o_Valid  out  1  queue head holds an instruction for decode.
- o_Instr  out  32  queue-head instruction.
- o_InstrPc  out  32  address of o_Instr.
- i_Ready  in  1  decode consumes the head when o_Valid=1 and i_Ready=1.
- i_Redirect  in  1  redirect request from execute.
- i_RedirectPc  in  32  redirect target.
- o_Fault  out  1  misaligned-redirect fault (see Configuration).
- o_FaultPc  out  32  offending redirect target.

## Operation
- States: RUN, HOLD (request presented, WaitReq high), FAULT (macro only).
- Issue rule: o_RdEn=1 when occupancy + inflight - pop < 2, where pop = o_Valid & i_Ready and inflight ≤ 1. PC advances by 4 on acceptance.
- HOLD: o_RdEn and o_CpuAddr stay constant until acceptance. A held request is never withdrawn.
- Response cycle: i_CpuRd and its PC are written to the queue tail unless squashed.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle are both performed. Pushes never overflow because of the credit rule.
- Redirect in RUN:
  - Queue is cleared, and any response arriving next cycle is squashed (o_OZero=1 and no push).
  - PC is loaded with i_RedirectPc. The cycle's pop is discarded; the redirect wins.
- Redirect in HOLD:
  - Target is latched as pending, and the held request stays presented until accepted.
  - Its response is squashed.
  - The next issued address is the pending target.
  - A second redirect before acceptance overwrites the pending target.
- Reset (including mid-HOLD): outputs return to reset values. The held request is dropped; the bus side restarts after reset.

## Timing
- Reset values:
  - o_RdEn=0, o_CpuAddr=RESET_PC, o_OZero=0.
  - o_Valid=0, o_Instr=0, o_InstrPc=0.
  - o_Fault=0, o_FaultPc=0.
- First o_RdEn=1 in the first cycle after i_Rst falls, with address RESET_PC.
- Latency: request accepted at cycle N, data on i_CpuRd at N+1, o_Valid=1 at N+2.
- Throughput: with i_Ready=1 and no wait states, one instruction per cycle sustained.
- Redirect at cycle N: first request at N+1 with address i_RedirectPc. o_Valid stays 0 at N+1 and N+2, and is 1 at N+3 for the target at the earliest.
- o_OZero is asserted only in the response cycle of a squashed request.

## Configuration
- IFETCH_MISALIGN_FAULT_EN defined:
  - A redirect with i_RedirectPc[1:0]≠0 clears the queue, squashes in-flight reads and enters FAULT.
  - FAULT holds o_Fault=1 and o_FaultPc=target, with no requests issued.
  - A later aligned redirect leaves FAULT and fetches normally.
  - If the redirect arrives in HOLD, the fault is raised after the held request is accepted.
- Undefined: bits [1:0] of the target are forced to 0 silently. o_Fault and o_FaultPc are tied to 0. The FAULT state does not exist.

## Test plan
- Reset release, RESET_PC=0x100, zero wait, i_Ready=1 -> addresses 0x100, 0x104, 0x108 on consecutive cycles; o_Valid from cycle 3 with o_InstrPc in order.
- i_Ready=0 for 5 cycles -> at most 2 queued entries, o_RdEn drops; after release, entries 0x100 and 0x104 appear in order with none lost or duplicated.
- i_IBus_WaitReq high 3 cycles on address 0x104 -> o_CpuAddr is held at 0x104, the PC does not advance, and data is accepted on the 4th cycle.
- i_Redirect to 0x200 with a response in flight -> o_OZero=1 next cycle, the squashed word never reaches o_Valid, and the next o_InstrPc is 0x200.
- Redirect to 0x300 during a WaitReq stall, then a redirect to 0x400 before acceptance -> the held read completes squashed, and the first new fetch is 0x400.
- With the macro defined, redirect to 0x202 -> o_Fault=1, o_FaultPc=0x202, no o_RdEn; a later redirect to 0x400 clears the fault. Without the macro, a redirect to 0x202 fetches 0x200.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues IBus word reads and buffers responses in a
// 2-entry queue toward decode. Optional misaligned-redirect fault: IFETCH_MISALIGN_FAULT_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic        o_RdEn,
    output logic [31:0] o_CpuAddr,
    output logic        o_OZero,
    input  logic [31:0] i_CpuRd,
    input  logic        i_IBus_WaitReq,
    output logic        o_Valid,
    output logic [31:0] o_Instr,
    output logic [31:0] o_InstrPc,
    input  logic        i_Ready,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPc,
    output logic        o_Fault,
    output logic [31:0] o_FaultPc
);

`ifdef IFETCH_MISALIGN_FAULT_EN
    typedef enum logic [1:0] {StRun, StHold, StFault} state_e;
`else
    typedef enum logic [1:0] {StRun, StHold} state_e;
`endif

    state_e      st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        squash_q, squash_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] q_instr_q [2];
    logic [31:0] q_instr_d [2];
    logic [31:0] q_pc_q [2];
    logic [31:0] q_pc_d [2];

    logic        pop, push, rd_en, accept, held;
    logic [2:0]  occ;
    logic [31:0] tgt;

`ifdef IFETCH_MISALIGN_FAULT_EN
    logic [31:0] fault_pc_q, fault_pc_d;
    assign tgt = i_RedirectPc;
`else
    logic unused_rpc;
    assign tgt        = {i_RedirectPc[31:2], 2'b00};
    assign unused_rpc = ^i_RedirectPc[1:0];
`endif

    assign o_Valid   = (count_q != 2'd0);
    assign o_Instr   = q_instr_q[0];
    assign o_InstrPc = q_pc_q[0];
    assign pop       = o_Valid & i_Ready;

    // Credit: queued + in-flight entries after this cycle's pop must leave room for one more.
    assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en  = !i_Rst && ((st_q == StHold) || ((st_q == StRun) && (occ < 3'd2)));
    assign accept = rd_en & ~i_IBus_WaitReq;
    assign held   = rd_en & i_IBus_WaitReq;

    assign o_RdEn    = rd_en;
    assign o_CpuAddr = pc_q;
    assign o_OZero   = inflight_q & squash_q;
    assign push      = inflight_q & ~squash_q & ~i_Redirect;

`ifdef IFETCH_MISALIGN_FAULT_EN
    assign o_Fault   = (st_q == StFault);
    assign o_FaultPc = (st_q == StFault) ? fault_pc_q : 32'd0;
`else
    assign o_Fault   = 1'b0;
    assign o_FaultPc = 32'd0;
`endif

    always_comb begin
        st_d          = st_q;
        pc_d          = pc_q;
        inflight_d    = accept;
        inflight_pc_d = inflight_pc_q;
        squash_d      = 1'b0;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
`ifdef IFETCH_MISALIGN_FAULT_EN
        fault_pc_d    = fault_pc_q;
`endif
        if (accept) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
            st_d          = StRun;
            if (pend_q) begin
                squash_d = 1'b1;
                pend_d   = 1'b0;
`ifdef IFETCH_MISALIGN_FAULT_EN
                if (|pend_pc_q[1:0]) begin
                    st_d       = StFault;
                    fault_pc_d = pend_pc_q;
                    pc_d       = pc_q;
                end else begin
                    pc_d = pend_pc_q;
                end
`else
                pc_d = pend_pc_q;
`endif
            end
        end else if (held) begin
            st_d = StHold;
        end

        if (i_Redirect) begin
            if (held) begin
                // The held request stays on the bus; the target takes effect after acceptance.
                pend_d    = 1'b1;
                pend_pc_d = tgt;
            end else begin
                squash_d = accept;
                pend_d   = 1'b0;
                st_d     = StRun;
`ifdef IFETCH_MISALIGN_FAULT_EN
                if (|tgt[1:0]) begin
                    st_d       = StFault;
                    fault_pc_d = tgt;
                    pc_d       = pc_q;
                end else begin
                    pc_d = tgt;
                end
`else
                pc_d = tgt;
`endif
            end
        end
    end

    always_comb begin
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        count_d   = count_q;
        if (i_Redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                q_instr_d[0] = q_instr_q[1];
                q_pc_d[0]    = q_pc_q[1];
                count_d      = count_q - 2'd1;
            end
            if (push) begin
                q_instr_d[count_d[0]] = i_CpuRd;
                q_pc_d[count_d[0]]    = inflight_pc_q;
                count_d               = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            st_q          <= StRun;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            squash_q      <= 1'b0;
            pend_q        <= 1'b0;
            pend_pc_q     <= 32'd0;
            count_q       <= 2'd0;
            q_instr_q[0]  <= 32'd0;
            q_instr_q[1]  <= 32'd0;
            q_pc_q[0]     <= 32'd0;
            q_pc_q[1]     <= 32'd0;
`ifdef IFETCH_MISALIGN_FAULT_EN
            fault_pc_q    <= 32'd0;
`endif
        end else begin
            st_q          <= st_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            count_q       <= count_d;
            q_instr_q     <= q_instr_d;
            q_pc_q        <= q_pc_d;
`ifdef IFETCH_MISALIGN_FAULT_EN
            fault_pc_q    <= fault_pc_d;
`endif
        end
    end

endmodule
